// File: rtl/msg_lfsr_gen.sv
// Multi-channel pseudo-random message generator: one start pulse expands a seed
// into a counted, back-pressurable stream of per-channel Galois LFSR words.
module msg_lfsr_gen #(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] TAPS   = 64'hD800_0000_0000_0000,
  parameter int unsigned      NUM_CH = 4,
  parameter int unsigned      CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          seed,
  input  logic [CNT_W-1:0]          count,
  input  logic                      ready,
  output logic                      valid,
  output logic [NUM_CH*WIDTH-1:0]   msg,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] lfsr_p0 [NUM_CH];
  logic             vld_p0;
  logic             busy_p0;
  logic             done_p0;

  // One Galois shift: the bit falling out of the LSB folds the tap mask back in.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ TAPS) : shifted;
  endfunction

  // Per-channel seed decorrelation; an all-zero state would lock the LFSR up.
  function automatic logic [WIDTH-1:0] chan_init(input logic [WIDTH-1:0] sd,
                                                 input int unsigned      c);
    logic [WIDTH-1:0] v;
    v = sd ^ WIDTH'(c + 1);
    return (v == '0) ? '1 : v;
  endfunction

  // Stage p0: control FSM, channel states and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      vld_p0    <= 1'b0;
      busy_p0   <= 1'b0;
      done_p0   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        lfsr_p0[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done_p0 <= 1'b0;
          if (start) begin
            if (count != '0) begin
              for (int c = 0; c < NUM_CH; c++) begin
                lfsr_p0[c] <= chan_init(seed, c);
              end
              remaining <= count;
              vld_p0    <= 1'b1;
              busy_p0   <= 1'b1;
              state     <= RUN;
            end else begin
              done_p0 <= 1'b1;
              state   <= FIN;
            end
          end
        end

        RUN: begin
          if (ready) begin
            for (int c = 0; c < NUM_CH; c++) begin
              lfsr_p0[c] <= lfsr_step(lfsr_p0[c]);
            end
            if (remaining != '0) begin
              remaining <= remaining - CNT_W'(1);
            end
            // remaining==0 cannot occur in RUN; treating it as the last word keeps the FSM from sticking.
            if (remaining <= CNT_W'(1)) begin
              vld_p0  <= 1'b0;
              busy_p0 <= 1'b0;
              done_p0 <= 1'b1;
              state   <= FIN;
            end
          end
        end

        FIN: begin
          done_p0 <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          vld_p0  <= 1'b0;
          busy_p0 <= 1'b0;
          done_p0 <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_msg
    assign msg[g*WIDTH +: WIDTH] = lfsr_p0[g];
  end

  assign valid = vld_p0;
  assign busy  = busy_p0;
  assign done  = done_p0;

endmodule

// File: tb/tb_msg_lfsr_gen.sv
// Scoreboard bench for msg_lfsr_gen: directed runs push hand-computed word sets,
// a negedge monitor compares every presented msg against the queue head.
module tb_msg_lfsr_gen;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int CW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   seed;
  logic [CW-1:0]  count;
  logic           ready;
  logic           valid;
  logic [N*W-1:0] msg;
  logic           busy;
  logic           done;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int runs_exp = 0;
  logic [N*W-1:0] sb [$];

  msg_lfsr_gen #(
    .WIDTH (W),
    .TAPS  (64'hD800_0000_0000_0000),
    .NUM_CH(N),
    .CNT_W (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .seed (seed),
    .count(count),
    .ready(ready),
    .valid(valid),
    .msg  (msg),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] w4(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                        input logic [W-1:0] c2, input logic [W-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented word set must match the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", valid, 1'b0);
        end else begin
          check("msg", msg, sb[0]);
          if (ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic start_run(input logic [W-1:0] s, input logic [CW-1:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    seed  = s;
    count = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    runs_exp++;
    if (n != 0) begin
      check("start_valid", valid, 1'b1);
      check("start_busy", busy, 1'b1);
      check("start_done", done, 1'b0);
    end else begin
      check("zero_valid", valid, 1'b0);
      check("zero_busy", busy, 1'b0);
      check("zero_done", done, 1'b1);
    end
  endtask

  task automatic wait_done(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("done_seen", found, 1'b1);
    if (found) begin
      check("valid_at_done", valid, 1'b0);
      check("busy_at_done", busy, 1'b0);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      #1;
      check("sb_drained", sb.size(), 0);
      check("done_pulses", done_cnt, runs_exp);
    end
  endtask

  initial begin
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    seed  = '0;
    count = '0;
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_msg", msg, '0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // seed=0, count=3, ready held high
    sb.push_back(w4(64'h1, 64'h2, 64'h3, 64'h4));
    sb.push_back(w4(64'hD800_0000_0000_0000, 64'h1, 64'hD800_0000_0000_0001, 64'h2));
    sb.push_back(w4(64'h6C00_0000_0000_0000, 64'hD800_0000_0000_0000,
                    64'hB400_0000_0000_0000, 64'h1));
    start_run(64'h0, 32'd3);
    wait_done(20);

    // seed=1: channel 0 hits the zero guard
    sb.push_back(w4(64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'h2, 64'h5));
    sb.push_back(w4(64'hA7FF_FFFF_FFFF_FFFF, 64'hD800_0000_0000_0001,
                    64'h1, 64'hD800_0000_0000_0002));
    start_run(64'h1, 32'd2);
    wait_done(20);

    // seed=0, count=4 with back-pressure pattern
    sb.push_back(w4(64'h1, 64'h2, 64'h3, 64'h4));
    sb.push_back(w4(64'hD800_0000_0000_0000, 64'h1, 64'hD800_0000_0000_0001, 64'h2));
    sb.push_back(w4(64'h6C00_0000_0000_0000, 64'hD800_0000_0000_0000,
                    64'hB400_0000_0000_0000, 64'h1));
    sb.push_back(w4(64'h3600_0000_0000_0000, 64'h6C00_0000_0000_0000,
                    64'h5A00_0000_0000_0000, 64'hD800_0000_0000_0000));
    start_run(64'h0, 32'd4);
    for (int i = 0; i < 7; i++) begin
      ready = pat[i];
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    wait_done(20);

    // count=0: done only
    start_run(64'h1234, 32'd0);
    wait_done(5);

    // start pulsed mid-run with another seed is ignored
    sb.push_back(w4(64'h1, 64'h2, 64'h3, 64'h4));
    sb.push_back(w4(64'hD800_0000_0000_0000, 64'h1, 64'hD800_0000_0000_0001, 64'h2));
    sb.push_back(w4(64'h6C00_0000_0000_0000, 64'hD800_0000_0000_0000,
                    64'hB400_0000_0000_0000, 64'h1));
    start_run(64'h0, 32'd3);
    start = 1'b1;
    seed  = 64'h5;
    count = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(20);

    // asynchronous reset mid-run
    sb.push_back(w4(64'h1, 64'h2, 64'h3, 64'h4));
    sb.push_back(w4(64'hD800_0000_0000_0000, 64'h1, 64'hD800_0000_0000_0001, 64'h2));
    sb.push_back(w4(64'h6C00_0000_0000_0000, 64'hD800_0000_0000_0000,
                    64'hB400_0000_0000_0000, 64'h1));
    sb.push_back(w4(64'h3600_0000_0000_0000, 64'h6C00_0000_0000_0000,
                    64'h5A00_0000_0000_0000, 64'hD800_0000_0000_0000));
    start_run(64'h0, 32'd4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_msg", msg, '0);
    sb.delete();
    runs_exp--;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check("midrst_no_done", done_cnt, runs_exp);

    sb.push_back(w4(64'h1, 64'h2, 64'h3, 64'h4));
    start_run(64'h0, 32'd1);
    wait_done(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/msg_lfsr_gen.md
# msg_lfsr_gen

Parametrised multi-channel message generator for the DES datapath. It expands one start pulse and a seed into a bounded stream of pseudo-random plaintext words, emitting one word per channel per transfer. Each channel runs an independent Galois LFSR. The block sits upstream of the DES encryption lanes and replaces single-seed, free-running message generation with counted, back-pressurable, multi-lane generation.

## Interface
- WIDTH, 64: message/LFSR width in bits (>= 8).
- TAPS, 64'hD800_0000_0000_0000: Galois feedback mask, WIDTH bits (x^64+x^63+x^61+x^60+1 at default).
- NUM_CH, 4: number of parallel channels (1..16).
- CNT_W, 32: width of the transfer counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- seed  in  WIDTH  base seed, sampled together with start.
- count  in  CNT_W  number of transfers in the run, sampled together with start.
- ready  in  1  consumer accepts msg this cycle.
- valid  out  1  msg holds a valid word set.
- msg  out  NUM_CH*WIDTH  channel c at msg[c*WIDTH +: WIDTH].
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at the end of a run.

## Operation
- FSM states are IDLE, RUN and FIN.
- IDLE, start=1 and count!=0: load the channel states and remaining=count, then go to RUN.
- IDLE, start=1 and count==0: go to FIN. No data is emitted.
- RUN: valid=1 and msg shows the current states. On valid&&ready, every channel steps once and remaining decrements. If remaining was 1, go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- Channel init value is init_c = seed ^ (c+1), zero-extended to WIDTH.
  - If init_c == 0, load {WIDTH{1'b1}} instead. This zero guard applies per channel.
- LFSR step: s' = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1). All channels step in lockstep.
- remaining is CNT_W bits and never wraps: decrement happens only on a transfer while remaining >= 1.
- start while in RUN or FIN is ignored; the run is not restarted and seed/count are not resampled.
- ready while not in RUN is ignored.
- Reset, including mid-run: state to IDLE; valid, busy, done = 0; msg = 0; remaining = 0. The run is abandoned and there is no done pulse.

## Timing
- Reset values: valid=0, busy=0, done=0, msg=0.
- Start latency: start sampled at edge k gives valid=1 and busy=1 after edge k, i.e. the first word is presented in cycle k+1.
- Throughput: one transfer per cycle while ready=1.
- Back-pressure: while valid=1 and ready=0, msg holds stable and nothing advances.
- Last transfer at edge t: valid=0, busy=0, done=1 in cycle t+1. IDLE from cycle t+2, and start is accepted at edge t+2.
- count==0: done=1 in the cycle after the start edge. valid never rises.
- valid, busy, done and msg are registered outputs. No combinational path from ready or start to any output.
- valid never depends combinationally on ready.

## Test plan
- Defaults, seed=0, count=3, ready=1 -> ch0 words 1, D800_0000_0000_0000, 6C00_0000_0000_0000. ch1 words 2, 1, D800_0000_0000_0000. Exactly 3 valid cycles, done one cycle after the last.
- seed=64'h1, count=2 -> ch0 zero-guarded to FFFF_FFFF_FFFF_FFFF, then A7FF_FFFF_FFFF_FFFF. ch1 = 3, then D800_0000_0000_0001.
- seed=0, count=4, ready toggled 1,0,0,1,1,0,1 -> msg constant during ready=0. Same 4-word sequence as with ready held at 1. done after the 4th accepted word.
- count=0 -> valid stays 0, done pulses once in the cycle after start, back to IDLE.
- start pulsed again mid-run with a different seed -> sequence unchanged, single done pulse.
- rst_n=0 asserted mid-run (asynchronous, between edges) -> valid, busy, done and msg drop to 0 immediately. After release, start with seed=0, count=1 yields ch0=1.
